// File: rtl/ser_pkg.sv
// Shared definitions for the serial word link (transmitter and receiver).
package ser_pkg;

  localparam int SER_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/word_serializer_bit_counter.sv
// Bit position counter: clears on load, advances on increment, flags the last position.
module bit_counter #(
  parameter int COUNT = 16
) (
  input  logic i_clock,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == LAST);

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: accepts a word on valid/ready and shifts it out
// one bit per clock, flagging the final bit; back-to-back words stream without gaps.
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             r_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  ser_state_t       r_state;
  ser_state_t       w_next;
  logic [WIDTH-1:0] r_shreg;
  logic             w_tc;
  logic             w_last;
  logic             w_accept;
  logic             w_clear;
  logic             w_inc;

  bit_counter #(
    .COUNT (WIDTH)
  ) u_bit_counter (
    .i_clock (clock),
    .i_rst_n (r_n),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clock or negedge r_n) begin
    if (!r_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Ready is also offered on the final bit so the next word follows with no idle gap.
  always_comb begin
    w_next   = r_state;
    w_last   = (r_state == SHIFT) && w_tc;
    in_ready = r_n && ((r_state == IDLE) || w_last);
    w_accept = in_valid && in_ready;
    w_clear  = w_accept || w_last;
    w_inc    = (r_state == SHIFT);
    case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (w_last && !w_accept) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge r_n) begin
    if (!r_n) begin
      r_shreg <= '0;
    end else if (w_accept) begin
      r_shreg <= in_data;
    end else if (w_last) begin
      r_shreg <= '0;
    end else if (r_state == SHIFT) begin
      if (LSB_FIRST) r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      else           r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign ser_out   = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
  assign ser_valid = (r_state == SHIFT);
  assign busy      = (r_state == SHIFT);
  assign ser_last  = w_last;

endmodule
